seq_detect_param: RTL and testbench

Parametrised Moore serial-pattern detector, the generalised successor of the fixed 4-bit "1101" detectors in the FSM library. It matches any pattern up to 16 bits. Overlapped or non-overlapped matching is chosen at run time. A valid qualifier stalls matching without losing progress, and a saturating counter tallies matches. It sits directly on a 1-bit serial data stream, and its `detect` output drives downstream framing and trigger logic.

---
 rtl/seq_detect_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/seq_detect_param.sv | 70 +++++++
 tb/tb_seq_detect_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised
// serial-pattern detector: state width and the KMP-style transition rule.
package seq_detect_pkg;

  localparam int MAX_LEN = 16;

  // Bits needed to hold states 0..len.
  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] pattern,
                                   input int len, input int i);
    logic [MAX_LEN-1:0] tmp;
    tmp = pattern >> (len - 1 - i);
    return tmp[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // Capped at len, so from the full-match state this yields the overlap target.
  function automatic int next_state(input logic [MAX_LEN-1:0] pattern,
                                    input int len, input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    if (k > len || len > MAX_LEN || len < 1) return 0;
    best = 0;
    for (int j = 1; j <= MAX_LEN; j++) begin
      if (j <= len && j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_LEN; t++) begin
          if (t < j) begin
            idx = k + 1 - j + t;
            sb  = (idx < k) ? pat_bit(pattern, len, idx) : b;
            if (pat_bit(pattern, len, t) != sb) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for state so all registers update together at the edge.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector. State k means the last k
// accepted bits equal the first k pattern bits; state PAT_LEN is the match.
// Overlap vs non-overlap is chosen when leaving the match state.
module seq_detect_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ovl_en,
  input  logic             in_valid,
  input  logic             in,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt
);

  import seq_detect_pkg::*;

  localparam int                 SW      = state_w(PAT_LEN);
  localparam int                 NSTATES = 1 << SW;
  localparam logic [MAX_LEN-1:0] PAT_EXT = MAX_LEN'(PATTERN);
  localparam logic [SW-1:0]      S_IDLE  = '0;
  localparam logic [SW-1:0]      S_MATCH = SW'(PAT_LEN);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] ns_tbl [NSTATES][2];
  logic          cnt_inc;

  // Transition table built at elaboration; unreachable codes fall back to idle.
  for (genvar k = 0; k < NSTATES; k++) begin : g_tbl
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NS = (k <= PAT_LEN) ? next_state(PAT_EXT, PAT_LEN, k, 1'(b)) : 0;
      assign ns_tbl[k][b] = SW'(NS);
    end
  end

  // Next state: clear dominates, stall holds, non-overlap restarts from idle.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else if (in_valid) begin
      if ((state_q == S_MATCH) && !ovl_en) state_d = ns_tbl[S_IDLE][in];
      else                                  state_d = ns_tbl[state_q][in];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Count every accepted edge that lands in the match state.
  assign cnt_inc = !clr && in_valid && (state_d == S_MATCH);

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (clr),
    .inc_i (cnt_inc),
    .cnt_o (match_cnt)
  );

  // Moore output decoded from the registered state only.
  assign detect = (state_q == S_MATCH);

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a sliding-window reference model
// predicts detect/match_cnt for three instances (1101/8-bit count,
// 11/2-bit count, 11/8-bit count) and each cycle's prediction is compared.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic ovl = 1'b1;
  logic v0 = 1'b0, b0 = 1'b0, v1 = 1'b0, b1 = 1'b0;

  logic       det0, det1, det2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_param dut0 (
    .clk(clk), .rst(rst), .clr(clr), .ovl_en(ovl), .in_valid(v0), .in(b0),
    .detect(det0), .match_cnt(cnt0)
  );

  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .ovl_en(ovl), .in_valid(v1), .in(b1),
    .detect(det1), .match_cnt(cnt1)
  );

  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .ovl_en(ovl), .in_valid(v1), .in(b1),
    .detect(det2), .match_cnt(cnt2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference model: shift history plus count of usable bits.
  int         m_len  [3];
  logic [15:0] m_pat [3];
  int         m_max  [3];
  logic [15:0] m_hist[3];
  int         m_avail[3];
  logic       m_hit  [3];
  int         m_cnt  [3];

  typedef struct { int id; logic det; int cnt; } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = '0; m_avail[i] = 0; m_hit[i] = 1'b0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int id, input logic v, input logic b, input logic c,
                            input logic o);
    logic [15:0] mask;
    mask = 16'((32'd1 << m_len[id]) - 1);
    if (c) begin
      m_hist[id] = '0; m_avail[id] = 0; m_hit[id] = 1'b0; m_cnt[id] = 0;
    end else if (v) begin
      if (m_hit[id] && !o) m_avail[id] = 0;
      m_hist[id]  = {m_hist[id][14:0], b};
      if (m_avail[id] < m_len[id]) m_avail[id]++;
      m_hit[id] = (m_avail[id] >= m_len[id]) && ((m_hist[id] & mask) == m_pat[id]);
      if (m_hit[id] && m_cnt[id] < m_max[id]) m_cnt[id]++;
    end
  endtask

  function automatic logic act_det(input int id);
    case (id)
      0:       return det0;
      1:       return det1;
      default: return det2;
    endcase
  endfunction

  function automatic int act_cnt(input int id);
    case (id)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // One clock: drive, predict, push, clock, pop and compare.
  task automatic step(input string tag, input logic iv0, input logic ib0,
                      input logic iv1, input logic ib1, input logic ic);
    exp_t e;
    v0 = iv0; b0 = ib0; v1 = iv1; b1 = ib1; clr = ic;
    model_step(0, iv0, ib0, ic, ovl);
    model_step(1, iv1, ib1, ic, ovl);
    model_step(2, iv1, ib1, ic, ovl);
    for (int i = 0; i < 3; i++) begin
      e.id = i; e.det = m_hit[i]; e.cnt = m_cnt[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s det%0d", tag, e.id), 32'(act_det(e.id)), 32'(e.det));
      check($sformatf("%s cnt%0d", tag, e.id), act_cnt(e.id), e.cnt);
    end
  endtask

  task automatic feed0(input string tag, input string bits);
    for (int i = 0; i < bits.len(); i++)
      step(tag, 1'b1, bits.getc(i) == 8'h31, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed1(input string tag, input string bits);
    for (int i = 0; i < bits.len(); i++)
      step(tag, 1'b0, 1'b0, 1'b1, bits.getc(i) == 8'h31, 1'b0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Mid-cycle asynchronous reset: outputs must drop without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, " det0"}, 32'(det0), 32'd0);
    check({tag, " cnt0"}, 32'(cnt0), 32'd0);
    check({tag, " cnt1"}, 32'(cnt1), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " held det0"}, 32'(det0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_len[0] = 4; m_pat[0] = 16'b1101; m_max[0] = 255;
    m_len[1] = 2; m_pat[1] = 16'b11;   m_max[1] = 3;
    m_len[2] = 2; m_pat[2] = 16'b11;   m_max[2] = 255;
    model_reset();

    #12;
    check("reset det0", 32'(det0), 32'd0);
    check("reset cnt0", 32'(cnt0), 32'd0);
    check("reset det1", 32'(det1), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    ovl = 1'b1;
    feed0("ovl 1101101", "1101101");

    step("clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    ovl = 1'b0;
    feed0("novl 1101101", "1101101");
    step("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    feed0("novl 11011101", "11011101");

    step("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ovl = 1'b1;
    feed0("stall pre", "110");
    idle("stall gap", 5);
    feed0("stall last", "1");
    ovl = 1'b0;
    idle("stall match", 4);

    async_reset("arst match");
    feed0("after arst", "1");

    ovl = 1'b1;
    feed1("ovl 11 x6", "111111");
    step("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    feed0("three", "1101101101");
    feed0("partial", "11");
    step("clr mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    feed0("post clr", "1101");

    feed0("pre arst", "110");
    async_reset("arst 110");
    feed0("restart", "1");
    feed0("restart full", "101");

    for (int i = 0; i < 400; i++) begin
      ovl = 1'($urandom_range(0, 1));
      step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
